// File: rtl/spi_cfg_master_if.sv
// Command interface of spi_cfg_master.
// Signals:
//   cmd_valid  requester -> master  command request
//   cmd_ready  master -> requester  idle and able to accept a command
//   cmd_addr   requester -> master  configuration register index
//   cmd_data   requester -> master  value to write
//   done       master -> requester  one-cycle pulse at frame completion
//   ack_err    master -> requester  valid with done; slave did not answer
// Modports: master = command source (sequencer / test logic), slave = spi_cfg_master.
interface spi_cfg_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       done;
  logic       ack_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_data,
    input  cmd_ready, done, ack_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data,
    output cmd_ready, done, ack_err
  );
endinterface

// File: rtl/spi_cfg_master.sv
// SPI write-frame generator for the demoscene configuration slave.
// Each accepted command becomes one frame: a flush SCLK pulse with SSEL high (clears
// the slave's counters), then SSEL low carrying {8'h00, 4'h0, addr, data} MSB first,
// then one trailing SCLK pulse on which the slave commits the write.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   cmd          command handshake (spi_cfg_master_if.slave)
//   SCLK         SPI clock, idles low
//   SSEL         active-low slave select, idles high
//   MOSI         serial data out, MSB first
//   MISO         slave response
// Parameter CLK_DIV: clk cycles per SCLK half-period (1..255).
// Optional macro SPI_ACK_CHECK_EN: sample MISO at the end of each SCLK high phase for
// bits 22..0 and the trailing pulse; any 0 sample raises ack_err with done.
module spi_cfg_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_cfg_master_if.slave cmd,
  output logic            SCLK,
  output logic            SSEL,
  output logic            MOSI,
  input  logic            MISO
);

  typedef enum logic [2:0] {StIdle, StFlush, StSetup, StShift, StTrail, StDone} state_e;

  localparam logic [7:0] HalfLast = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic        phase_q, phase_d;  // 1: SCLK high half-period
  logic [4:0]  bit_q, bit_d;
  logic [23:0] shreg_q, shreg_d;
  logic        err_q, err_d;
  logic        sclk_q, sclk_d;
  logic        ssel_q, ssel_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic        accept;
  logic        half_end;

  // ready_q is high only in IDLE, so this also implies the FSM is idle.
  assign accept   = cmd.cmd_valid & ready_q;
  assign half_end = (hcnt_q == HalfLast);

`ifndef SPI_ACK_CHECK_EN
  logic unused_miso;
  assign unused_miso = MISO;
`endif

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    err_d   = err_q;

    if (state_q != StIdle && state_q != StDone) begin
      hcnt_d = half_end ? 8'd0 : hcnt_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StFlush;
          phase_d = 1'b1;
          hcnt_d  = 8'd0;
          shreg_d = {8'h00, 4'h0, cmd.cmd_addr, cmd.cmd_data};
          err_d   = 1'b0;
        end
      end
      StFlush: begin
        if (half_end) begin
          if (phase_q) phase_d = 1'b0;
          else         state_d = StSetup;
        end
      end
      StSetup: begin
        if (half_end) begin
          state_d = StShift;
          phase_d = 1'b1;
          bit_d   = 5'd23;
        end
      end
      StShift: begin
        if (half_end) begin
          if (phase_q) begin
            // Falling edge: present the next bit; zeros fill in behind bit 0.
            phase_d = 1'b0;
            shreg_d = {shreg_q[22:0], 1'b0};
          end else if (bit_q == 5'd0) begin
            state_d = StTrail;
            phase_d = 1'b1;
          end else begin
            bit_d   = bit_q - 5'd1;
            phase_d = 1'b1;
          end
        end
      end
      StTrail: begin
        if (half_end) begin
          if (phase_q) phase_d = 1'b0;
          else         state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef SPI_ACK_CHECK_EN
    // The slave only drives MISO high after its first select-low edge, so bit 23 is skipped.
    if (half_end && phase_q && !MISO &&
        ((state_q == StShift && bit_q <= 5'd22) || state_q == StTrail)) begin
      err_d = 1'b1;
    end
`endif

    // Outputs are registered from the next state so they line up with state_q.
    ssel_d  = !(state_d inside {StSetup, StShift, StTrail});
    sclk_d  = phase_d && (state_d inside {StFlush, StShift, StTrail});
    mosi_d  = (state_d inside {StSetup, StShift}) ? shreg_d[23] : 1'b0;
    ready_d = (state_d == StIdle);
    done_d  = (state_d == StDone);
`ifdef SPI_ACK_CHECK_EN
    ack_err_d = (state_d == StDone) && err_d;
`else
    ack_err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hcnt_q    <= 8'd0;
      phase_q   <= 1'b0;
      bit_q     <= 5'd0;
      shreg_q   <= 24'd0;
      err_q     <= 1'b0;
      sclk_q    <= 1'b0;
      ssel_q    <= 1'b1;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      err_q     <= err_d;
      sclk_q    <= sclk_d;
      ssel_q    <= ssel_d;
      mosi_q    <= mosi_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign SCLK          = sclk_q;
  assign SSEL          = ssel_q;
  assign MOSI          = mosi_q;
  assign cmd.cmd_ready = ready_q;
  assign cmd.done      = done_q;
  assign cmd.ack_err   = ack_err_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: two instances (CLK_DIV=2 and CLK_DIV=1) each driving a
// behavioural configuration-slave model that decodes frames from the SPI pins.
module tb_spi_cfg_master;
  localparam int unsigned Div0 = 2;
  localparam int unsigned Div1 = 1;
`ifdef SPI_ACK_CHECK_EN
  localparam bit AckOn = 1'b1;
`else
  localparam bit AckOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_cfg_master_if if0 ();
  spi_cfg_master_if if1 ();

  logic sclk0, ssel0, mosi0, miso0;
  logic sclk1, ssel1, mosi1, miso1;
  logic [1:0] slv_miso = 2'b00;
  logic [1:0] miso_tie0 = 2'b00;
  assign miso0 = slv_miso[0] & ~miso_tie0[0];
  assign miso1 = slv_miso[1] & ~miso_tie0[1];

  spi_cfg_master #(.CLK_DIV(Div0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd(if0.slave),
    .SCLK(sclk0), .SSEL(ssel0), .MOSI(mosi0), .MISO(miso0)
  );
  spi_cfg_master #(.CLK_DIV(Div1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd(if1.slave),
    .SCLK(sclk1), .SSEL(ssel1), .MOSI(mosi1), .MISO(miso1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model state and frame statistics, per instance.
  int          rise_cnt[2], low_cyc[2], done_cnt[2], commit_cnt[2], nbits[2];
  logic [23:0] rx[2], last_word[2];
  logic        trail_mosi[2], prev_sc[2];
  logic [7:0]  s_bg[2];
  logic [5:0]  s_sc[2];
  logic        s_ae[2];

  // Reference register contents, updated from commands.
  logic [7:0]  m_bg[2];
  logic [5:0]  m_sc[2];
  logic        m_ae[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Slave: rising SCLK with SSEL high clears counters; with SSEL low, 24 bits are
  // shifted in and the 25th select-low edge commits the write.
  task automatic slave_step(input int k, input logic sc, input logic ss, input logic mo,
                            input logic dn);
    if (!ss) low_cyc[k]++;
    if (dn) done_cnt[k]++;
    if (sc && !prev_sc[k]) begin
      rise_cnt[k]++;
      if (ss) begin
        nbits[k] = 0;
      end else begin
        if (nbits[k] < 24) begin
          rx[k] = {rx[k][22:0], mo};
        end else if (nbits[k] == 24) begin
          trail_mosi[k] = mo;
          last_word[k]  = rx[k];
          commit_cnt[k]++;
          case (rx[k][15:8])
            8'd0: s_bg[k] = rx[k][7:0];
            8'd1: s_sc[k] = rx[k][5:0];
            8'd2: s_ae[k] = rx[k][0];
            default: ;
          endcase
        end
        nbits[k]++;
        slv_miso[k] = 1'b1;
      end
    end
    if (ss) slv_miso[k] = 1'b0;
    prev_sc[k] = sc;
  endtask

  always @(negedge clk) begin
    slave_step(0, sclk0, ssel0, mosi0, if0.done);
    slave_step(1, sclk1, ssel1, mosi1, if1.done);
  end

  function automatic logic get_ready(input int k);
    return (k == 0) ? if0.cmd_ready : if1.cmd_ready;
  endfunction
  function automatic logic get_done(input int k);
    return (k == 0) ? if0.done : if1.done;
  endfunction
  function automatic logic get_ack(input int k);
    return (k == 0) ? if0.ack_err : if1.ack_err;
  endfunction
  function automatic int unsigned div_of(input int k);
    return (k == 0) ? Div0 : Div1;
  endfunction

  task automatic drive(input int k, input logic v, input logic [3:0] a, input logic [7:0] d);
    if (k == 0) begin
      if0.cmd_valid = v; if0.cmd_addr = a; if0.cmd_data = d;
    end else begin
      if1.cmd_valid = v; if1.cmd_addr = a; if1.cmd_data = d;
    end
  endtask

  task automatic model_apply(input int k, input logic [3:0] a, input logic [7:0] d);
    if (a == 4'd0) m_bg[k] = d;
    else if (a == 4'd1) m_sc[k] = d[5:0];
    else if (a == 4'd2) m_ae[k] = d[0];
  endtask

  // Raise cmd_valid and return once the accepting edge has passed (caller at posedge+1).
  task automatic issue(input int k, input logic [3:0] a, input logic [7:0] d, output int waited);
    drive(k, 1'b1, a, d);
    waited = 0;
    while (!get_ready(k) && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    check($sformatf("k%0d_accept_ready", k), 32'(get_ready(k)), 32'd1);
    @(posedge clk); #1;
    rise_cnt[k] = 0; low_cyc[k] = 0; done_cnt[k] = 0; commit_cnt[k] = 0;
  endtask

  task automatic wait_done(input int k, output logic ack, output int viol);
    int cyc = 0;
    viol = 0;
    while (!get_done(k) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (!get_done(k) && get_ready(k)) viol++;
    end
    check($sformatf("k%0d_done_seen", k), 32'(get_done(k)), 32'd1);
    ack = get_ack(k);
  endtask

  task automatic frame_checks(input int k, input logic [3:0] a, input logic [7:0] d,
                              input logic ack, input int viol);
    check($sformatf("k%0d_ack_err", k), 32'(ack), 32'(AckOn && miso_tie0[k]));
    check($sformatf("k%0d_ready_busy", k), 32'(viol), 32'd0);
    check($sformatf("k%0d_sclk_rises", k), 32'(rise_cnt[k]), 32'd26);
    check($sformatf("k%0d_ssel_low", k), 32'(low_cyc[k]), 32'(51 * div_of(k)));
    check($sformatf("k%0d_word", k), 32'(last_word[k]), {8'h00, 8'h00, 4'h0, a, d});
    check($sformatf("k%0d_trail_mosi", k), 32'(trail_mosi[k]), 32'd0);
    check($sformatf("k%0d_commits", k), 32'(commit_cnt[k]), 32'd1);
    check($sformatf("k%0d_bg", k), 32'(s_bg[k]), 32'(m_bg[k]));
    check($sformatf("k%0d_sc", k), 32'(s_sc[k]), 32'(m_sc[k]));
    check($sformatf("k%0d_ae", k), 32'(s_ae[k]), 32'(m_ae[k]));
  endtask

  task automatic do_frame(input int k, input logic [3:0] a, input logic [7:0] d);
    int   w;
    int   viol;
    logic ack;
    @(posedge clk); #1;
    issue(k, a, d, w);
    check($sformatf("k%0d_idle_accept_wait", k), 32'(w), 32'd0);
    drive(k, 1'b0, a, d);
    wait_done(k, ack, viol);
    model_apply(k, a, d);
    frame_checks(k, a, d, ack, viol);
    @(negedge clk); #1;
    check($sformatf("k%0d_done_pulses", k), 32'(done_cnt[k]), 32'd1);
  endtask

  typedef struct {
    int         k;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] bg;
    logic [5:0] sc;
    logic       ae;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   w;
    int   viol;
    int   cyc;
    logic ack;

    tbl[0] = '{0, 4'd0, 8'hA5, 8'hA5, 6'h00, 1'b0};
    tbl[1] = '{0, 4'd1, 8'h2A, 8'hA5, 6'h2A, 1'b0};
    tbl[2] = '{0, 4'd2, 8'h01, 8'hA5, 6'h2A, 1'b1};
    tbl[3] = '{0, 4'd7, 8'hFF, 8'hA5, 6'h2A, 1'b1};
    tbl[4] = '{0, 4'd1, 8'hFF, 8'hA5, 6'h3F, 1'b1};
    tbl[5] = '{1, 4'd0, 8'h5A, 8'h5A, 6'h00, 1'b0};
    tbl[6] = '{1, 4'd1, 8'h15, 8'h5A, 6'h15, 1'b0};

    for (int k = 0; k < 2; k++) begin
      rise_cnt[k] = 0; low_cyc[k] = 0; done_cnt[k] = 0; commit_cnt[k] = 0; nbits[k] = 0;
      rx[k] = '0; last_word[k] = '0; trail_mosi[k] = 1'b0; prev_sc[k] = 1'b0;
      s_bg[k] = '0; s_sc[k] = '0; s_ae[k] = 1'b0;
      m_bg[k] = '0; m_sc[k] = '0; m_ae[k] = 1'b0;
      drive(k, 1'b0, 4'd0, 8'd0);
    end

    // Reset values.
    #2 rst_n = 1'b0;
    #20;
    check("rst_ssel", 32'(ssel0), 32'd1);
    check("rst_sclk", 32'(sclk0), 32'd0);
    check("rst_mosi", 32'(mosi0), 32'd0);
    check("rst_ready", 32'(if0.cmd_ready), 32'd0);
    check("rst_done", 32'(if0.done), 32'd0);
    check("rst_ack_err", 32'(if0.ack_err), 32'd0);
    check("rst_ssel_k1", 32'(ssel1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(if0.cmd_ready), 32'd1);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      do_frame(tbl[i].k, tbl[i].a, tbl[i].d);
      check($sformatf("tbl%0d_bg", i), 32'(s_bg[tbl[i].k]), 32'(tbl[i].bg));
      check($sformatf("tbl%0d_sc", i), 32'(s_sc[tbl[i].k]), 32'(tbl[i].sc));
      check($sformatf("tbl%0d_ae", i), 32'(s_ae[tbl[i].k]), 32'(tbl[i].ae));
    end

    // Back-to-back frames with cmd_valid held high.
    @(posedge clk); #1;
    issue(1, 4'd1, 8'h3F, w);
    wait_done(1, ack, viol);
    model_apply(1, 4'd1, 8'h3F);
    frame_checks(1, 4'd1, 8'h3F, ack, viol);
    issue(1, 4'd2, 8'h01, w);
    check("b2b_accept_gap", 32'(w), 32'd1);
    drive(1, 1'b0, 4'd0, 8'd0);
    wait_done(1, ack, viol);
    model_apply(1, 4'd2, 8'h01);
    frame_checks(1, 4'd2, 8'h01, ack, viol);
    check("b2b_solid_color", 32'(s_sc[1]), 32'h3F);
    check("b2b_audio_en", 32'(s_ae[1]), 32'd1);

    // Inputs changed after acceptance and a valid pulse while busy are ignored.
    @(posedge clk); #1;
    issue(0, 4'd0, 8'h11, w);
    drive(0, 1'b0, 4'd1, 8'hEE);
    repeat (10) @(posedge clk);
    #1;
    drive(0, 1'b1, 4'd1, 8'hEE);
    check("busy_ready_low", 32'(if0.cmd_ready), 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd1, 8'hEE);
    wait_done(0, ack, viol);
    model_apply(0, 4'd0, 8'h11);
    frame_checks(0, 4'd0, 8'h11, ack, viol);
    repeat (30) @(posedge clk);
    #1;
    check("busy_single_done", 32'(done_cnt[0]), 32'd1);
    check("busy_single_commit", 32'(commit_cnt[0]), 32'd1);
    check("busy_idle_ready", 32'(if0.cmd_ready), 32'd1);

    // Reset during SHIFT bit 10 abandons the frame without a commit.
    @(posedge clk); #1;
    issue(0, 4'd0, 8'h77, w);
    drive(0, 1'b0, 4'd0, 8'h00);
    cyc = 0;
    while (nbits[0] != 14 && cyc < 1000) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("reach_bit10", 32'(nbits[0]), 32'd14);
    rst_n = 1'b0;
    #1;
    check("abort_ssel", 32'(ssel0), 32'd1);
    check("abort_sclk", 32'(sclk0), 32'd0);
    check("abort_mosi", 32'(mosi0), 32'd0);
    check("abort_ready", 32'(if0.cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_commit", 32'(commit_cnt[0]), 32'd0);
    check("abort_bg_kept", 32'(s_bg[0]), 32'(m_bg[0]));
    do_frame(0, 4'd0, 8'h42);

    // MISO tied low: ack_err expected only when the check is built in.
    miso_tie0[0] = 1'b1;
    do_frame(0, 4'd2, 8'h00);
    miso_tie0[0] = 1'b0;
    miso_tie0[1] = 1'b1;
    do_frame(1, 4'd0, 8'h99);
    miso_tie0[1] = 1'b0;
    do_frame(1, 4'd2, 8'h01);

    // Randomized frames against the reference model.
    for (int i = 0; i < 16; i++) begin
      do_frame(int'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
